// File: rtl/ball_ctrl_pkg.sv
// Shared types and default sizing for the ball-and-plate axis controller.
package ball_ctrl_pkg;

  localparam int unsigned PosWDefault      = 13;
  localparam int unsigned AngleWDefault    = 11;
  localparam int unsigned GainWDefault     = 16;
  localparam int unsigned FracBitsDefault  = 10;
  localparam int          AngleOffsetDefault = 85;
  localparam int          AngleMinDefault  = -1024;
  localparam int          AngleMaxDefault  = 1023;

  typedef enum logic [2:0] {
    StIdle,
    StMulPos,
    StMulVel,
    StMulRef,
    StFinish
  } ctrl_state_e;

  // Each product is at most 2^(G-1) * 2^P in magnitude (delta carries one extra bit), so the
  // three-term sum plus rounding bias stays below 2^(G+P+1); two spare bits keep it clear.
  function automatic int unsigned acc_width(input int unsigned gain_w, input int unsigned pos_w);
    return gain_w + pos_w + 3;
  endfunction

endpackage

// File: rtl/ctrl_round_sat.sv
// Combinational fixed-point round (half-up), offset add and clamp with saturation flag.
module ctrl_round_sat
  import ball_ctrl_pkg::*;
#(
  parameter int unsigned InW      = 32,
  parameter int unsigned OutW     = 11,
  parameter int unsigned FracBits = 10,
  parameter int          Offset   = 85,
  parameter int          MinVal   = -1024,
  parameter int          MaxVal   = 1023
) (
  input  logic signed [InW-1:0]  acc_i,
  output logic signed [OutW-1:0] val_o,
  output logic                   sat_o
);

  // Wide enough for the input plus headroom and for any 32-bit limit/offset constant.
  localparam int unsigned ExtW = ((InW > 32) ? InW : 32) + 2;

  localparam logic signed [ExtW-1:0] HalfC = ExtW'(1) <<< (FracBits - 1);
  localparam logic signed [ExtW-1:0] OffC  = ExtW'(Offset);
  localparam logic signed [ExtW-1:0] MinC  = ExtW'(MinVal);
  localparam logic signed [ExtW-1:0] MaxC  = ExtW'(MaxVal);

  logic signed [ExtW-1:0] ext;
  logic signed [ExtW-1:0] shifted;
  logic signed [ExtW-1:0] biased;

  // Round, offset and clamp at full width so nothing wraps before the range check.
  always_comb begin
    ext     = {{(ExtW-InW){acc_i[InW-1]}}, acc_i};
    shifted = (ext + HalfC) >>> FracBits;
    biased  = shifted + OffC;
    val_o   = biased[OutW-1:0];
    sat_o   = 1'b0;
    if (biased > MaxC) begin
      val_o = MaxC[OutW-1:0];
      sat_o = 1'b1;
    end else if (biased < MinC) begin
      val_o = MinC[OutW-1:0];
      sat_o = 1'b1;
    end
  end

endmodule

// File: rtl/ball_axis_lqr_controller.sv
// Single-axis state-feedback position controller: one shared multiplier sequenced by an FSM
// computes k_pos*pos + k_vel*delta + k_ref*desired, then rounds, offsets and clamps.
module ball_axis_lqr_controller
  import ball_ctrl_pkg::*;
#(
  parameter int unsigned POS_W        = PosWDefault,
  parameter int unsigned ANGLE_W      = AngleWDefault,
  parameter int unsigned GAIN_W       = GainWDefault,
  parameter int unsigned FRAC_BITS    = FracBitsDefault,
  parameter int          ANGLE_OFFSET = AngleOffsetDefault,
  parameter int          ANGLE_MIN    = AngleMinDefault,
  parameter int          ANGLE_MAX    = AngleMaxDefault
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      sample_strobe,
  input  logic signed [POS_W-1:0]   desired_pos,
  input  logic signed [POS_W-1:0]   actual_pos,
  input  logic signed [GAIN_W-1:0]  k_pos,
  input  logic signed [GAIN_W-1:0]  k_vel,
  input  logic signed [GAIN_W-1:0]  k_ref,
  output logic signed [ANGLE_W-1:0] angle,
  output logic                      angle_valid,
  output logic                      saturated,
  output logic                      busy,
  output logic                      overrun
);

  localparam int unsigned OpW   = POS_W + 1;
  localparam int unsigned ProdW = GAIN_W + OpW;
  localparam int unsigned AccW  = acc_width(GAIN_W, POS_W);

  localparam logic signed [ANGLE_W-1:0] ResetAngle = ANGLE_W'(ANGLE_OFFSET);

  ctrl_state_e state_q;

  logic signed [POS_W-1:0]  pos_q;
  logic signed [POS_W-1:0]  desired_q;
  logic signed [POS_W-1:0]  prev_pos_q;
  logic signed [OpW-1:0]    delta_q;
  logic signed [GAIN_W-1:0] k_pos_q;
  logic signed [GAIN_W-1:0] k_vel_q;
  logic signed [GAIN_W-1:0] k_ref_q;
  logic                     first_sample_q;
  logic signed [AccW-1:0]   acc_q;

  logic signed [OpW-1:0]    delta_d;
  logic signed [GAIN_W-1:0] mul_gain;
  logic signed [OpW-1:0]    mul_op;
  logic signed [ProdW-1:0]  product;
  logic signed [AccW-1:0]   product_ext;
  logic signed [ANGLE_W-1:0] rs_angle;
  logic                     rs_sat;

  // Per-sample position change; the very first sample after reset has no history.
  always_comb begin
    delta_d = '0;
    if (!first_sample_q) begin
      delta_d = {actual_pos[POS_W-1], actual_pos} - {prev_pos_q[POS_W-1], prev_pos_q};
    end
  end

  // Operand select for the single shared multiplier, sign-extended to full product width.
  always_comb begin
    mul_gain = '0;
    mul_op   = '0;
    case (state_q)
      StMulPos: begin
        mul_gain = k_pos_q;
        mul_op   = {pos_q[POS_W-1], pos_q};
      end
      StMulVel: begin
        mul_gain = k_vel_q;
        mul_op   = delta_q;
      end
      StMulRef: begin
        mul_gain = k_ref_q;
        mul_op   = {desired_q[POS_W-1], desired_q};
      end
      default: ;
    endcase
    product     = $signed({{OpW{mul_gain[GAIN_W-1]}}, mul_gain}) *
                  $signed({{GAIN_W{mul_op[OpW-1]}}, mul_op});
    product_ext = {{(AccW-ProdW){product[ProdW-1]}}, product};
  end

  ctrl_round_sat #(
    .InW      (AccW),
    .OutW     (ANGLE_W),
    .FracBits (FRAC_BITS),
    .Offset   (ANGLE_OFFSET),
    .MinVal   (ANGLE_MIN),
    .MaxVal   (ANGLE_MAX)
  ) u_round_sat (
    .acc_i (acc_q),
    .val_o (rs_angle),
    .sat_o (rs_sat)
  );

  // Sequencer: latch on strobe, accumulate three products, then publish the clamped angle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= StIdle;
      pos_q          <= '0;
      desired_q      <= '0;
      prev_pos_q     <= '0;
      delta_q        <= '0;
      k_pos_q        <= '0;
      k_vel_q        <= '0;
      k_ref_q        <= '0;
      first_sample_q <= 1'b1;
      acc_q          <= '0;
      angle          <= ResetAngle;
      angle_valid    <= 1'b0;
      saturated      <= 1'b0;
      busy           <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      angle_valid <= 1'b0;
      // A strobe in any non-idle state is dropped; only the sticky flag records it.
      if (sample_strobe && (state_q != StIdle)) begin
        overrun <= 1'b1;
      end
      case (state_q)
        StIdle: begin
          if (sample_strobe) begin
            pos_q          <= actual_pos;
            desired_q      <= desired_pos;
            k_pos_q        <= k_pos;
            k_vel_q        <= k_vel;
            k_ref_q        <= k_ref;
            delta_q        <= delta_d;
            prev_pos_q     <= actual_pos;
            first_sample_q <= 1'b0;
            busy           <= 1'b1;
            state_q        <= StMulPos;
          end
        end
        StMulPos: begin
          acc_q   <= product_ext;
          state_q <= StMulVel;
        end
        StMulVel: begin
          acc_q   <= acc_q + product_ext;
          state_q <= StMulRef;
        end
        StMulRef: begin
          acc_q   <= acc_q + product_ext;
          state_q <= StFinish;
        end
        StFinish: begin
          angle       <= rs_angle;
          saturated   <= rs_sat;
          angle_valid <= 1'b1;
          busy        <= 1'b0;
          state_q     <= StIdle;
        end
        default: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
